e_mult_div_unit: RTL and testbench
==================================

Name: e_mult_div_unit

Overview:
- Execute-stage multiply/divide unit for the pipelined MIPS core.
- Produces the multdiv result that the E/M pipeline register samples into M.
- Owns the HI/LO registers and runs multi-cycle MULT/MULTU/DIV/DIVU.
- Exposes a stall request to the hazard unit, which freezes the F/D and D/E registers while the unit is occupied.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high; sampled on posedge clk
start  input  1  one-cycle issue strobe from E stage
op  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
A  input  32  rs operand, forwarded value
B  input  32  rt operand, forwarded value
sel_hi  input  1  result select: 1 = HI (MFHI), 0 = LO (MFLO)
busy  output  1  registered; high while an operation is in flight
stall_req  output  1  combinational: busy | (start & op in 1..4)
multdiv_res_E  output  32  combinational: sel_hi ? HI : LO
HI  output  32  registered HI
LO  output  32  registered LO

Behaviour:
- Reset (posedge clk with reset=1): HI=0, LO=0, busy=0, cycle counter=0, latched operands/op cleared. Reset wins over start and over an in-flight operation; an aborted operation never commits.
- States:
  - IDLE (busy=0)
  - RUN (busy=1, counter counts down)
- IDLE -> RUN: start=1 with op 1..4 at posedge.
  - Latch A, B and op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - busy rises the following cycle.
- RUN: counter decrements each posedge. On the posedge where the counter equals 1:
  - Commit HI/LO.
  - busy=0 from the next cycle; return to IDLE.
  - busy is high for exactly N cycles, and the new HI/LO are visible the cycle busy falls.
- Arithmetic on latched operands:
  - MULT: {HI,LO} = signed 64-bit A*B.
  - MULTU: {HI,LO} = unsigned 64-bit A*B.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B=0, DIV or DIVU): the unit still goes busy for DIV_CYCLES, then HI/LO are left unchanged.
- MTHI/MTLO in IDLE: HI<=A or LO<=A at the same posedge as start. No busy, stall_req=0.
- start with any op while busy=1: ignored; no state change. The hazard unit guarantees this does not occur; the bench checks that it is ignored.
- start with op 0 or 7: no effect.
- multdiv_res_E reflects committed HI/LO only. While busy it shows the old values; reading during busy is prevented by stall_req at the hazard unit.
- stall_req is asserted in the issue cycle itself, so a following MFHI/MFLO stays in D until the result commits.
- Operands A/B are only sampled on the issue edge; later changes are ignored.

Test Plan:
- MULT A=0xFFFFFFFF, B=0x00000002 -> stall_req=1 in the issue cycle; busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE, multdiv_res_E=LO with sel_hi=0.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- Preload HI=0x11, LO=0x22 via MTHI/MTLO (no busy, values visible the next cycle) -> DIVU B=0 gives 10 busy cycles, then HI=0x11, LO=0x22.
- During a DIV in flight: issue MTLO A=0x55 and MULT -> both ignored. Then reset in the 3rd busy cycle -> next cycle busy=0, HI=LO=0, and no later commit.
- Boundary: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. MULT 0x80000000 * 0x80000000 -> HI=0x40000000, LO=0.

Source files
------------

// File: rtl/e_mult_div_unit_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
// The E stage (master) issues operations; the unit (slave) returns HI/LO and stall status.
interface e_mult_div_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        sel_hi;
    logic        busy;
    logic        stall_req;
    logic [31:0] multdiv_res_E;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, A, B, sel_hi,
        input  busy, stall_req, multdiv_res_E, HI, LO
    );

    modport slave (
        input  start, op, A, B, sel_hi,
        output busy, stall_req, multdiv_res_E, HI, LO
    );
endinterface

// File: rtl/e_mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO and models fixed-latency MULT/DIV
// with a countdown; results commit on the last busy cycle.
module e_mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    e_mult_div_unit_if.slave     bus
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        a_q, b_q;
    op_e                op_q;
    logic [31:0]        hi_q, lo_q;

    op_e                op_in;
    logic               is_md_op;
    logic               is_div_op;
    logic               issue;
    logic               commit;

    logic signed [63:0] a_sx, b_sx;
    logic [63:0]        prod_s, prod_u;
    logic [31:0]        res_hi, res_lo;
    logic               res_we;

    assign op_in     = op_e'(bus.op);
    assign is_md_op  = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
                       (op_in == OP_DIV)  || (op_in == OP_DIVU);
    assign is_div_op = (op_in == OP_DIV)  || (op_in == OP_DIVU);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && is_md_op) begin
                    state_d = S_RUN;
                    issue   = 1'b1;
                    cnt_d   = is_div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Arithmetic always works on the operands captured at issue, never on live inputs.
    assign a_sx   = {{32{a_q[31]}}, a_q};
    assign b_sx   = {{32{b_q[31]}}, b_q};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        res_we = 1'b0;
        case (op_q)
            OP_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_we = 1'b1;
            end
            OP_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_we = 1'b1;
            end
            OP_DIV: begin
                if (b_q != 32'd0) begin
                    res_we = 1'b1;
                    // The only signed overflow case; pinned so it never depends on tool semantics.
                    if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                        res_lo = 32'h8000_0000;
                        res_hi = 32'd0;
                    end else begin
                        res_lo = $signed(a_q) / $signed(b_q);
                        res_hi = $signed(a_q) % $signed(b_q);
                    end
                end
            end
            OP_DIVU: begin
                if (b_q != 32'd0) begin
                    res_we = 1'b1;
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_NONE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (issue) begin
                a_q  <= bus.A;
                b_q  <= bus.B;
                op_q <= op_in;
            end
            if (commit && res_we) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state_q == S_IDLE && bus.start) begin
                if (op_in == OP_MTHI) hi_q <= bus.A;
                if (op_in == OP_MTLO) lo_q <= bus.A;
            end
        end
    end

    assign bus.busy          = (state_q == S_RUN);
    assign bus.stall_req     = bus.busy | (bus.start & is_md_op);
    assign bus.multdiv_res_E = bus.sel_hi ? hi_q : lo_q;
    assign bus.HI            = hi_q;
    assign bus.LO            = lo_q;

endmodule

// File: tb/tb_e_mult_div_unit.sv
// Scoreboard bench for e_mult_div_unit: stimulus pushes expected commits, a monitor
// pops and compares each time busy falls.
module tb_e_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    e_mult_div_unit_if bus();

    e_mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: a busy 1->0 transition is the point where a result is presented.
    initial begin
        logic busy_prev = 1'b0;
        int   run = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy_prev === 1'b1 && bus.busy === 1'b0) begin
                if (sb.size() == 0) begin
                    check("unexpected_busy_fall", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_busy_len"}, 32'(run), 32'(e.len));
                    check({e.name, "_HI"}, bus.HI, e.hi);
                    check({e.name, "_LO"}, bus.LO, e.lo);
                    check({e.name, "_res"}, bus.multdiv_res_E, bus.sel_hi ? e.hi : e.lo);
                end
            end
            run       = (bus.busy === 1'b1) ? run + 1 : 0;
            busy_prev = bus.busy;
        end
    end

    // Drive for one cycle, verify stall_req in the issue cycle, then scramble operands.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_stall, input string name);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        #1;
        check({name, "_stall_req"}, 32'(bus.stall_req), 32'(exp_stall));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) done = 1'b1;
        end
        if (!done) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input int len,
                          input logic sel, input string name);
        exp_t e;
        e.hi = hi; e.lo = lo; e.len = len; e.name = name;
        sb.push_back(e);
        bus.sel_hi = sel;
        issue(op, a, b, 1'b1, name);
        wait_idle(name);
    endtask

    initial begin
        exp_t e;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.A      = '0;
        bus.B      = '0;
        bus.sel_hi = 1'b0;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_HI", bus.HI, 32'd0);
        check("reset_LO", bus.LO, 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);

        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MULT_N, 1'b0, "mult_neg");
        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, MULT_N, 1'b1, "multu");
        run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N, 1'b0, "div_neg");
        run_op(3'd4, 32'd7, 32'd2, 32'd1, 32'd3, DIV_N, 1'b1, "divu");

        issue(3'd5, 32'h11, 32'h0, 1'b0, "mthi");
        @(negedge clk);
        check("mthi_busy", 32'(bus.busy), 32'd0);
        check("mthi_HI", bus.HI, 32'h11);
        issue(3'd6, 32'h22, 32'h0, 1'b0, "mtlo");
        @(negedge clk);
        check("mtlo_busy", 32'(bus.busy), 32'd0);
        check("mtlo_LO", bus.LO, 32'h22);

        run_op(3'd4, 32'd5, 32'd0, 32'h11, 32'h22, DIV_N, 1'b0, "divu_by_zero");
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_N, 1'b0, "div_ovf");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, MULT_N, 1'b1, "mult_min");

        issue(3'd0, 32'hDEAD_BEEF, 32'h1, 1'b0, "op_none");
        issue(3'd7, 32'hDEAD_BEEF, 32'h1, 1'b0, "op_rsvd");
        @(negedge clk);
        check("noop_busy", 32'(bus.busy), 32'd0);
        check("noop_HI", bus.HI, 32'h4000_0000);
        check("noop_LO", bus.LO, 32'd0);

        // DIV in flight: extra issues are ignored, then reset in the 3rd busy cycle aborts it.
        e.hi = 32'd0; e.lo = 32'd0; e.len = 3; e.name = "div_abort";
        sb.push_back(e);
        bus.sel_hi = 1'b0;
        issue(3'd3, 32'd100, 32'd7, 1'b1, "div_abort");
        issue(3'd6, 32'h55, 32'h0, 1'b1, "mtlo_busy");
        issue(3'd1, 32'h3, 32'h3, 1'b1, "mult_busy");
        @(negedge clk);
        check("abort_pre_LO", bus.LO, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (DIV_N + 5) @(negedge clk);
        check("post_abort_busy", 32'(bus.busy), 32'd0);
        check("post_abort_HI", bus.HI, 32'd0);
        check("post_abort_LO", bus.LO, 32'd0);

        run_op(3'd4, 32'd100, 32'd7, 32'd2, 32'd14, DIV_N, 1'b1, "divu_after_reset");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
